modular_sub_pipe: RTL and testbench

// Streaming two-stage pipelined modular subtractor: z = (x - y) mod M for operands in [0, M).

---
 rtl/modular_sub_pipe.sv | 142 ++++++++++++++
 tb/tb_modular_sub_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/modular_sub_pipe.sv
// ---------------------------------------------------------------------------
// modular_sub_pipe
// Two-stage streaming modular subtractor: z = (x - y) mod M.
// Stage 1 forms the raw difference with its borrow and flags out-of-range
// operands; stage 2 folds a negative difference back by adding M.
// Valid/ready handshakes on both sides, one result per cycle, full
// backpressure. A sideband tag travels with every operand pair.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   operand pair presented
//   in_ready   pipeline accepts operands this cycle
//   x_sub      minuend (expected < M)
//   y_sub      subtrahend (expected < M)
//   in_tag     sideband tag, returned unchanged with the result
//   out_valid  result presented
//   out_ready  consumer accepts result this cycle
//   z_sub      (x_sub - y_sub) mod M
//   out_tag    tag of this result
//   out_err    1 when either operand of this result was >= M
// ---------------------------------------------------------------------------
module modular_sub_pipe #(
  parameter int unsigned           data_width = 64,
  parameter logic [data_width-1:0] M          = 64'hffff_ffff_0000_0001,
  parameter int unsigned           TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] x_sub,
  input  logic [data_width-1:0] y_sub,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] z_sub,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  // Stage 1 state
  logic                  r_s1_valid;
  logic                  r_s1_borrow;
  logic [data_width-1:0] r_s1_diff;
  logic [TAG_W-1:0]      r_s1_tag;
  logic                  r_s1_err;

  // Stage 2 state (drives the outputs directly)
  logic                  r_s2_valid;
  logic [data_width-1:0] r_z;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_err;

  // Combinational helpers
  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic [data_width:0]   w_diff_full;
  logic                  w_err_in;
  logic [data_width-1:0] w_z_next;

  // Handshake control and per-stage datapath arithmetic
  always_comb begin
    w_s2_adv    = 1'b0;
    w_s1_adv    = 1'b0;
    w_in_ready  = 1'b0;
    w_in_fire   = 1'b0;
    w_diff_full = '0;
    w_err_in    = 1'b0;
    w_z_next    = '0;

    w_s2_adv = ~r_s2_valid | out_ready;
    w_s1_adv = r_s1_valid & w_s2_adv;
    // Ready is forced high while reset is asserted so upstream never sees
    // a stale stall; nothing is captured during reset anyway.
    w_in_ready = ~rst_n | ~r_s1_valid | w_s2_adv;
    w_in_fire  = rst_n & in_valid & w_in_ready;

    // Extra top bit of the difference is the borrow out of the subtraction.
    w_diff_full = {1'b0, x_sub} - {1'b0, y_sub};
    w_err_in    = (x_sub >= M) | (y_sub >= M);

    // A borrow means the raw difference went negative; adding M (mod 2^W)
    // brings it back into the residue range.
    if (r_s1_borrow) begin
      w_z_next = r_s1_diff + M;
    end else begin
      w_z_next = r_s1_diff;
    end
  end

  // Stage 1 register: capture operands on an input handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_borrow <= 1'b0;
      r_s1_diff   <= '0;
      r_s1_tag    <= '0;
      r_s1_err    <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid  <= 1'b1;
        r_s1_borrow <= w_diff_full[data_width];
        r_s1_diff   <= w_diff_full[data_width-1:0];
        r_s1_tag    <= in_tag;
        r_s1_err    <= w_err_in;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
    end
  end

  // Stage 2 register: fold the difference and hold it while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_tag      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_z        <= w_z_next;
        r_tag      <= r_s1_tag;
        r_err      <= r_s1_err;
      end else begin
        r_s2_valid <= r_s2_valid & ~out_ready;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign z_sub     = r_z;
  assign out_tag   = r_tag;
  assign out_err   = r_err;

endmodule

// File: tb/tb_modular_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_modular_sub_pipe
// Directed and randomized checks of modular_sub_pipe against a reference
// model that computes each expected result straight from the arithmetic
// definition and keeps in-flight results in a queue.
// ---------------------------------------------------------------------------
module tb_modular_sub_pipe;

  localparam logic [63:0] MOD = 64'hffff_ffff_0000_0001;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_sub;
  logic [63:0] y_sub;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] z_sub;
  logic [7:0]  out_tag;
  logic        out_err;

  typedef struct packed {
    logic [63:0] z;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   n_out;

  modular_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_sub     (x_sub),
    .y_sub     (y_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_sub     (z_sub),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result from the arithmetic definition, not the datapath.
  function automatic exp_t ref_model(input logic [63:0] x, input logic [63:0] y,
                                     input logic [7:0] tg);
    exp_t        e;
    logic [127:0] t;
    e.tag = tg;
    e.err = (x >= MOD) || (y >= MOD);
    if (!e.err) begin
      t   = {64'd0, x} + {64'd0, MOD} - {64'd0, y};
      t   = t % {64'd0, MOD};
      e.z = t[63:0];
    end else if (x >= y) begin
      e.z = x - y;
    end else begin
      e.z = x - y + MOD;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance past the rising edge.
  task automatic step(input logic iv, input logic [63:0] x, input logic [63:0] y,
                      input logic [7:0] tg, input logic ordy);
    in_valid  = iv;
    x_sub     = x;
    y_sub     = y;
    in_tag    = tg;
    out_ready = ordy;
    @(negedge clk);
    if (!rst_n) begin
      chk("in_ready_rst", {63'd0, in_ready}, 64'd1);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || ordy});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          chk("z_sub", z_sub, q[0].z);
          chk("out_tag", {56'd0, out_tag}, {56'd0, q[0].tag});
          chk("out_err", {63'd0, out_err}, {63'd0, q[0].err});
          if (ordy) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (iv && in_ready) q.push_back(ref_model(x, y, tg));
    end
    @(posedge clk);
    if (!rst_n) q.delete();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) return MOD + 64'($urandom_range(0, 15));
    return v % MOD;
  endfunction

  initial begin
    int base;
    n_vec = 0; n_err = 0; n_out = 0;
    rst_n = 1'b1; in_valid = 1'b0; x_sub = 64'd0; y_sub = 64'd0;
    in_tag = 8'd0; out_ready = 1'b1;
    #1;

    // Reset state
    do_reset();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_z", z_sub, 64'd0);
    chk("rst_tag", {56'd0, out_tag}, 64'd0);
    chk("rst_err", {63'd0, out_err}, 64'd0);

    // Two-cycle latency: 5 - 3
    step(1'b1, 64'd5, 64'd3, 8'h11, 1'b1);
    chk("lat_cyc1_valid", {63'd0, out_valid}, 64'd0);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("lat_cyc2_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_z", z_sub, 64'd2);
    chk("lat_tag", {56'd0, out_tag}, 64'h11);
    chk("lat_err", {63'd0, out_err}, 64'd0);
    drain();

    // Wrap cases and equality
    step(1'b1, 64'd3, 64'd5, 8'h21, 1'b1);
    step(1'b1, 64'd0, MOD - 64'd1, 8'h22, 1'b1);
    chk("wrap_m2_z", z_sub, 64'hffff_fffe_ffff_ffff);
    step(1'b1, MOD - 64'd1, MOD - 64'd1, 8'h23, 1'b1);
    chk("wrap_one_z", z_sub, 64'd1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("equal_z", z_sub, 64'd0);
    drain();

    // Out-of-range operands
    step(1'b1, MOD, 64'd0, 8'h31, 1'b1);
    step(1'b1, 64'd0, MOD + 64'd1, 8'h32, 1'b1);
    chk("oor_x_z", z_sub, MOD);
    chk("oor_x_err", {63'd0, out_err}, 64'd1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("oor_y_err", {63'd0, out_err}, 64'd1);
    drain();

    // Back-to-back stream of 16 at full throughput
    base = n_out;
    for (int i = 0; i < 16; i++) step(1'b1, rnd_op(), rnd_op(), 8'(8'h40 + i), 1'b1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("stream_count", 64'(n_out - base), 64'd16);

    // Backpressure: both stages fill, then ready drops and outputs hold
    for (int i = 0; i < 4; i++) step(1'b1, rnd_op(), rnd_op(), 8'(8'h60 + i), 1'b0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_inflight", 64'(q.size()), 64'd2);
    base = n_out;
    drain();
    chk("bp_drain_count", 64'(n_out - base), 64'd2);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 8'($urandom),
           1'($urandom_range(0, 9) < 7));
    drain();

    // Reset with both stages full discards everything
    for (int i = 0; i < 3; i++) step(1'b1, rnd_op(), rnd_op(), 8'(8'h80 + i), 1'b0);
    chk("pre_rst_inflight", 64'(q.size()), 64'd2);
    rst_n = 1'b0;
    step(1'b1, 64'd7, 64'd1, 8'h99, 1'b0);
    rst_n = 1'b1;
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);

    // Pipeline still works after reset
    step(1'b1, 64'd9, 64'd4, 8'hA5, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
